// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings
// (also used by ID decode) and FSM state encodings.
package ex_muldiv_pkg;

   typedef logic [1:0] md_op_t;

   localparam md_op_t MD_MULT  = 2'b00;
   localparam md_op_t MD_MULTU = 2'b01;
   localparam md_op_t MD_DIV   = 2'b10;
   localparam md_op_t MD_DIVU  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_FIX  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   function automatic logic md_is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage (master) and the mul/div unit (slave).
interface ex_muldiv_if
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             start_i;
   md_op_t           op_i;
   logic [WIDTH-1:0] opa_i;
   logic [WIDTH-1:0] opb_i;
   logic             annul_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             dbz_o;

   modport master (
      output start_i, op_i, opa_i, opb_i, annul_i,
      input  busy_o, done_o, hi_o, lo_o, dbz_o
   );

   modport slave (
      input  start_i, op_i, opa_i, opb_i, annul_i,
      output busy_o, done_o, hi_o, lo_o, dbz_o
   );

endinterface

// File: rtl/ex_muldiv_core.sv
// One iteration of the datapath: shift-add multiply step or restoring-divide
// trial subtract, both through a single WIDTH+1 bit adder with carry out.
module ex_muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_a;
   logic [WIDTH:0]   w_b;
   logic             w_cin;
   logic [WIDTH+1:0] w_sum;
   logic             w_carry;

   always_comb begin
      w_shift = {i_hi, i_lo[WIDTH-1]};
      if (i_is_div) begin
         // subtract via add of the complement; carry out means no borrow
         w_a   = w_shift;
         w_b   = ~{1'b0, i_opnd};
         w_cin = 1'b1;
      end else begin
         w_a   = {1'b0, i_hi};
         w_b   = i_lo[0] ? {1'b0, i_opnd} : '0;
         w_cin = 1'b0;
      end
   end

   assign w_sum   = {1'b0, w_a} + {1'b0, w_b} + {{(WIDTH+1){1'b0}}, w_cin};
   assign w_carry = w_sum[WIDTH+1];

   always_comb begin
      if (i_is_div) begin
         o_hi = w_carry ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
         o_lo = {i_lo[WIDTH-2:0], w_carry};
      end else begin
         o_hi = w_sum[WIDTH:1];
         o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside EX: FSM, iteration counter,
// sign pre/post conditioning and the registered HI/LO result.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | WIDTH iterations of the core, counter 0..WIDTH-1
//   FIX   | sign correction, result captured on exit
//   DONE  | done_o high, result valid; start_i re-accepts
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_busy;
   logic               r_done;
   logic               r_dbz;
   logic [WIDTH-1:0]   r_res_hi;
   logic [WIDTH-1:0]   r_res_lo;

   logic               w_idle_or_done;
   logic               w_accept;
   logic               w_dbz;
   logic               w_op_div;
   logic               w_op_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_core_hi;
   logic [WIDTH-1:0]   w_core_lo;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic               w_last_iter;
   logic               w_finish;

   assign w_op_div       = md_is_div(bus.op_i);
   assign w_op_signed    = md_is_signed(bus.op_i);
   assign w_a_neg        = w_op_signed & bus.opa_i[WIDTH-1];
   assign w_b_neg        = w_op_signed & bus.opb_i[WIDTH-1];
   assign w_a_mag        = w_a_neg ? -bus.opa_i : bus.opa_i;
   assign w_b_mag        = w_b_neg ? -bus.opb_i : bus.opb_i;

   assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept       = bus.start_i & ~bus.annul_i & w_idle_or_done;
   assign w_dbz          = w_accept & w_op_div & (bus.opb_i == '0);
   assign w_last_iter    = (r_cnt == CW'(WIDTH - 1));
   assign w_finish       = (r_state == ST_FIX) & ~bus.annul_i;

   always_comb begin
      w_state_nxt = r_state;
      if (bus.annul_i) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_dbz)
                  w_state_nxt = ST_DONE;
               else if (w_accept)
                  w_state_nxt = ST_RUN;
               else
                  w_state_nxt = ST_IDLE;
            end
            ST_RUN:  w_state_nxt = w_last_iter ? ST_FIX : ST_RUN;
            ST_FIX:  w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   ex_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .i_is_div (r_is_div),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .i_opnd   (r_opnd),
      .o_hi     (w_core_hi),
      .o_lo     (w_core_lo)
   );

   // r_neg_q doubles as "product negative" for multiplies
   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo_fix  = r_neg_q ? -r_lo : r_lo;
   assign w_rem_fix  = r_neg_r ? -r_hi : r_hi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
         r_res_hi <= '0;
         r_res_lo <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FIX);
         r_done  <= (w_state_nxt == ST_DONE);

         if (w_accept) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_op_div ? w_a_mag : w_b_mag;
            r_opnd   <= w_op_div ? w_b_mag : w_a_mag;
            r_is_div <= w_op_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
         end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            r_hi  <= w_core_hi;
            r_lo  <= w_core_lo;
         end

         if (w_dbz) begin
            r_res_hi <= bus.opa_i;
            r_res_lo <= '1;
            r_dbz    <= 1'b1;
         end else if (w_finish) begin
            r_res_hi <= r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
            r_res_lo <= r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
            r_dbz    <= 1'b0;
         end
      end
   end

   assign bus.busy_o = r_busy;
   assign bus.done_o = r_done;
   assign bus.hi_o   = r_res_hi;
   assign bus.lo_o   = r_res_lo;
   assign bus.dbz_o  = r_dbz;

endmodule
